// File: rtl/sym_cn_lut_pkg.sv
// Shared definitions for the symbol CN LUT loader: FSM state encoding and
// the derivation of the page address width from the LUT geometry.
package sym_cn_lut_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_B0 = 3'd1,
    ST_GET_B1 = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Page address width: each page holds one entry per frame set, so the
  // frame-set index bits are removed from the entry address.
  function automatic int page_width(input int entryAddr, input int frameNum);
    return entryAddr - $clog2(frameNum);
  endfunction

endpackage

// File: rtl/sym_cn_lut_xor_acc.sv
// Running XOR of every accepted LUT entry, used to verify a table load
// against an expected checksum. Only instantiated when
// SYM_CN_LOADER_CHECKSUM_EN is defined.
module sym_cn_lut_xor_acc #(
  parameter int WIDTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_acc
);

  logic [WIDTH-1:0] r_acc;

  // Clear at the start of a load, then fold in each accepted entry.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/sym_cn_lut_loader.sv
// Symbol CN LUT loader: collects a stream of LUT entries in pairs (bank0,
// bank1) and writes each pair to one LUT page, walking all 2^PW pages once
// per load. Optional feature macro: SYM_CN_LOADER_CHECKSUM_EN adds an
// expected-checksum input and a load error flag.
module sym_cn_lut_loader
  import sym_cn_lut_pkg::*;
#(
  parameter  int LUT_PORT_SIZE   = 2,
  parameter  int ENTRY_ADDR      = 4,
  parameter  int MULTI_FRAME_NUM = 2,
  localparam int PW              = page_width(ENTRY_ADDR, MULTI_FRAME_NUM)
) (
  input  logic                     write_clk,
  input  logic                     rstn,
  input  logic                     load_start,
  input  logic                     load_offset,
  input  logic [LUT_PORT_SIZE-1:0] entry_in,
  input  logic                     entry_valid,
  output logic                     entry_ready,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank0,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank1,
  output logic [PW-1:0]            page_write_addr,
  output logic                     write_addr_offset,
  output logic                     we,
  output logic                     busy,
`ifdef SYM_CN_LOADER_CHECKSUM_EN
  input  logic [LUT_PORT_SIZE-1:0] exp_checksum,
  output logic                     load_err,
`endif
  output logic                     load_done
);

  state_t                   r_state;
  state_t                   w_nextState;
  logic [PW-1:0]            r_pageCnt;
  logic                     r_offset;
  logic [LUT_PORT_SIZE-1:0] r_bank0Hold;
  logic [LUT_PORT_SIZE-1:0] r_lutB0;
  logic [LUT_PORT_SIZE-1:0] r_lutB1;
  logic [PW-1:0]            r_pageAddr;
  logic                     r_offsetOut;
  logic                     w_accept;
  logic                     w_lastPage;
  logic                     w_startLoad;

  assign w_accept    = entry_valid & entry_ready;
  assign w_lastPage  = (r_pageCnt == '1);
  assign w_startLoad = (r_state == ST_IDLE) & load_start;

  // State register; reset abandons any load in progress.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control outputs decoded from the current state.
  always_comb begin
    w_nextState = r_state;
    entry_ready = 1'b0;
    we          = 1'b0;
    busy        = 1'b1;
    load_done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (load_start) w_nextState = ST_GET_B0;
      end
      ST_GET_B0: begin
        entry_ready = 1'b1;
        if (entry_valid) w_nextState = ST_GET_B1;
      end
      ST_GET_B1: begin
        entry_ready = 1'b1;
        if (entry_valid) w_nextState = ST_WRITE;
      end
      ST_WRITE: begin
        we          = 1'b1;
        w_nextState = w_lastPage ? ST_DONE : ST_GET_B0;
      end
      ST_DONE: begin
        load_done   = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Datapath: the offset is captured only when a load starts, bank0 is
  // parked until its partner arrives, and the write-side outputs all change
  // together on entry to WRITE so they stay stable whenever we is low.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_pageCnt   <= '0;
      r_offset    <= 1'b0;
      r_bank0Hold <= '0;
      r_lutB0     <= '0;
      r_lutB1     <= '0;
      r_pageAddr  <= '0;
      r_offsetOut <= 1'b0;
    end else begin
      if (w_startLoad) begin
        r_offset  <= load_offset;
        r_pageCnt <= '0;
      end
      if (w_accept && (r_state == ST_GET_B0)) begin
        r_bank0Hold <= entry_in;
      end
      if (w_accept && (r_state == ST_GET_B1)) begin
        r_lutB0     <= r_bank0Hold;
        r_lutB1     <= entry_in;
        r_pageAddr  <= r_pageCnt;
        r_offsetOut <= r_offset;
      end
      if (r_state == ST_WRITE) begin
        r_pageCnt <= r_pageCnt + PW'(1);
      end
    end
  end

  assign lut_in_bank0      = r_lutB0;
  assign lut_in_bank1      = r_lutB1;
  assign page_write_addr   = r_pageAddr;
  assign write_addr_offset = r_offsetOut;

`ifdef SYM_CN_LOADER_CHECKSUM_EN
  logic [LUT_PORT_SIZE-1:0] r_expSum;
  logic                     r_loadErr;
  logic [LUT_PORT_SIZE-1:0] w_acc;

  sym_cn_lut_xor_acc #(
    .WIDTH (LUT_PORT_SIZE)
  ) u_xor_acc (
    .i_clk   (write_clk),
    .i_rstn  (rstn),
    .i_clear (w_startLoad),
    .i_en    (w_accept),
    .i_data  (entry_in),
    .o_acc   (w_acc)
  );

  // Error flag is cleared by a new load and resolved as the last page is
  // written, so it is valid while load_done pulses and held afterwards.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_expSum  <= '0;
      r_loadErr <= 1'b0;
    end else if (w_startLoad) begin
      r_expSum  <= exp_checksum;
      r_loadErr <= 1'b0;
    end else if ((r_state == ST_WRITE) && w_lastPage) begin
      r_loadErr <= (w_acc != r_expSum);
    end
  end

  assign load_err = r_loadErr;
`endif

endmodule
